// File: rtl/rtc_secuenciador_if.sv
// rtl/rtc_secuenciador_if.sv - user-write, bus-engine and cached-register signals of the RTC scheduler
interface rtc_secuenciador_if;
    // User edit write request
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    // Bus-protocol engine transaction handshake
    logic       txn_start;
    logic       txn_rw;
    logic [7:0] txn_addr;
    logic [7:0] txn_wdata;
    logic       txn_done;
    logic [7:0] txn_rdata;
    // Cached register values for the VGA path
    logic [7:0] seg;
    logic [7:0] min;
    logic [7:0] hora;
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] anio;
    logic [7:0] seg_t;
    logic [7:0] min_t;
    logic [7:0] hora_t;
    // Status
    logic       sweep_done;
    logic       init_done;
    logic       bus_error;

    modport master (
        input  wr_req, wr_addr, wr_data, txn_done, txn_rdata,
        output wr_ack, txn_start, txn_rw, txn_addr, txn_wdata,
        output seg, min, hora, dia, mes, anio, seg_t, min_t, hora_t,
        output sweep_done, init_done, bus_error
    );

    modport slave (
        output wr_req, wr_addr, wr_data, txn_done, txn_rdata,
        input  wr_ack, txn_start, txn_rw, txn_addr, txn_wdata,
        input  seg, min, hora, dia, mes, anio, seg_t, min_t, hora_t,
        input  sweep_done, init_done, bus_error
    );
endinterface

// File: rtl/rtc_secuenciador.sv
// rtl/rtc_secuenciador.sv - RTC bus transaction scheduler: init writes, periodic read sweep, user write insertion
module rtc_secuenciador #(
    parameter int REFRESH_CYCLES = 2_000_000,
    parameter int TIMEOUT        = 1023
) (
    input  logic                clk,
    input  logic                reset,
    rtc_secuenciador_if.master  bus
);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_INIT_ISSUE = 3'd0;
    localparam logic [2:0] S_INIT_WAIT  = 3'd1;
    localparam logic [2:0] S_IDLE       = 3'd2;
    localparam logic [2:0] S_RD_ISSUE   = 3'd3;
    localparam logic [2:0] S_RD_WAIT    = 3'd4;
    localparam logic [2:0] S_WR_ISSUE   = 3'd5;
    localparam logic [2:0] S_WR_WAIT    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [3:0]    rd_idx_q, rd_idx_d;
    logic          sweep_active_q, sweep_active_d;
    logic          tick_pending_q, tick_pending_d;
    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          txn_start_q, txn_start_d;
    logic          txn_rw_q, txn_rw_d;
    logic [7:0]    txn_addr_q, txn_addr_d;
    logic [7:0]    txn_wdata_q, txn_wdata_d;
    logic          wr_ack_q, wr_ack_d;
    logic          sweep_done_q, sweep_done_d;
    logic          init_done_q, init_done_d;
    logic          bus_error_q, bus_error_d;
    logic [7:0]    regs_q [9];
    logic [7:0]    regs_d [9];

    logic refresh_wrap;
    logic wait_end;

    function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    sweep_addr = 8'h21;
            4'd1:    sweep_addr = 8'h22;
            4'd2:    sweep_addr = 8'h23;
            4'd3:    sweep_addr = 8'h24;
            4'd4:    sweep_addr = 8'h25;
            4'd5:    sweep_addr = 8'h26;
            4'd6:    sweep_addr = 8'h41;
            4'd7:    sweep_addr = 8'h42;
            default: sweep_addr = 8'h43;
        endcase
    endfunction

    function automatic logic [15:0] init_word(input logic [1:0] idx);
        case (idx)
            2'd0:    init_word = 16'h02_10;
            2'd1:    init_word = 16'h02_00;
            default: init_word = 16'h10_D2;
        endcase
    endfunction

    assign refresh_wrap = (refresh_cnt_q == REF_LAST);
    // A WAIT cycle ends the transaction on done, or on the last allowed cycle without done
    assign wait_end     = bus.txn_done || (wait_cnt_q == WAIT_LAST);

    // Next-state: sequencing FSM, refresh tick, transaction outputs and read cache
    always_comb begin
        state_d        = state_q;
        init_idx_d     = init_idx_q;
        rd_idx_d       = rd_idx_q;
        sweep_active_d = sweep_active_q;
        tick_pending_d = tick_pending_q;
        refresh_cnt_d  = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
        wait_cnt_d     = wait_cnt_q + 1'b1;
        txn_start_d    = 1'b0;
        txn_rw_d       = txn_rw_q;
        txn_addr_d     = txn_addr_q;
        txn_wdata_d    = txn_wdata_q;
        wr_ack_d       = 1'b0;
        sweep_done_d   = 1'b0;
        init_done_d    = init_done_q;
        bus_error_d    = bus_error_q;
        regs_d         = regs_q;

        case (state_q)
            S_INIT_ISSUE: begin
                txn_start_d = 1'b1;
                txn_rw_d    = 1'b0;
                txn_addr_d  = init_word(init_idx_q)[15:8];
                txn_wdata_d = init_word(init_idx_q)[7:0];
                wait_cnt_d  = '0;
                state_d     = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (wait_end) begin
                    if (!bus.txn_done) bus_error_d = 1'b1;
                    if (init_idx_q == 2'd2) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        state_d    = S_INIT_ISSUE;
                    end
                end
            end
            S_IDLE: begin
                if (bus.wr_req) begin
                    state_d = S_WR_ISSUE;
                end else if (tick_pending_q) begin
                    tick_pending_d = 1'b0;
                    rd_idx_d       = 4'd0;
                    sweep_active_d = 1'b1;
                    state_d        = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                txn_start_d = 1'b1;
                txn_rw_d    = 1'b1;
                txn_addr_d  = sweep_addr(rd_idx_q);
                txn_wdata_d = 8'h00;
                wait_cnt_d  = '0;
                state_d     = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_end) begin
                    if (bus.txn_done) begin
                        if (rd_idx_q < 4'd9) regs_d[rd_idx_q] = bus.txn_rdata;
                    end else begin
                        bus_error_d = 1'b1;
                    end
                    rd_idx_d = rd_idx_q + 4'd1;
                    // The last read closes the sweep even if a user write follows it
                    if (rd_idx_q >= 4'd8) begin
                        sweep_done_d   = 1'b1;
                        sweep_active_d = 1'b0;
                        state_d        = bus.wr_req ? S_WR_ISSUE : S_IDLE;
                    end else begin
                        state_d = bus.wr_req ? S_WR_ISSUE : S_RD_ISSUE;
                    end
                end
            end
            S_WR_ISSUE: begin
                txn_start_d = 1'b1;
                txn_rw_d    = 1'b0;
                txn_addr_d  = bus.wr_addr;
                txn_wdata_d = bus.wr_data;
                wait_cnt_d  = '0;
                state_d     = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (wait_end) begin
                    if (!bus.txn_done) bus_error_d = 1'b1;
                    wr_ack_d = 1'b1;
                    // Resume without re-checking wr_req so only one write fits per read boundary
                    state_d  = sweep_active_q ? S_RD_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Single-deep tick flag; a wrap while pending is absorbed
        if (refresh_wrap) tick_pending_d = 1'b1;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_INIT_ISSUE;
            init_idx_q     <= '0;
            rd_idx_q       <= '0;
            sweep_active_q <= 1'b0;
            tick_pending_q <= 1'b0;
            refresh_cnt_q  <= '0;
            wait_cnt_q     <= '0;
            txn_start_q    <= 1'b0;
            txn_rw_q       <= 1'b0;
            txn_addr_q     <= '0;
            txn_wdata_q    <= '0;
            wr_ack_q       <= 1'b0;
            sweep_done_q   <= 1'b0;
            init_done_q    <= 1'b0;
            bus_error_q    <= 1'b0;
            regs_q         <= '{default: 8'h00};
        end else begin
            state_q        <= state_d;
            init_idx_q     <= init_idx_d;
            rd_idx_q       <= rd_idx_d;
            sweep_active_q <= sweep_active_d;
            tick_pending_q <= tick_pending_d;
            refresh_cnt_q  <= refresh_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            txn_start_q    <= txn_start_d;
            txn_rw_q       <= txn_rw_d;
            txn_addr_q     <= txn_addr_d;
            txn_wdata_q    <= txn_wdata_d;
            wr_ack_q       <= wr_ack_d;
            sweep_done_q   <= sweep_done_d;
            init_done_q    <= init_done_d;
            bus_error_q    <= bus_error_d;
            regs_q         <= regs_d;
        end
    end

    assign bus.txn_start  = txn_start_q;
    assign bus.txn_rw     = txn_rw_q;
    assign bus.txn_addr   = txn_addr_q;
    assign bus.txn_wdata  = txn_wdata_q;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.init_done  = init_done_q;
    assign bus.bus_error  = bus_error_q;
    assign bus.seg        = regs_q[0];
    assign bus.min        = regs_q[1];
    assign bus.hora       = regs_q[2];
    assign bus.dia        = regs_q[3];
    assign bus.mes        = regs_q[4];
    assign bus.anio       = regs_q[5];
    assign bus.seg_t      = regs_q[6];
    assign bus.min_t      = regs_q[7];
    assign bus.hora_t     = regs_q[8];
endmodule

// File: tb/tb_rtc_secuenciador.sv
// tb/tb_rtc_secuenciador.sv - self-checking bench for rtc_secuenciador
`timescale 1ns/1ps
module tb_rtc_secuenciador;
    localparam int REFRESH = 100;
    localparam int TOUT    = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_secuenciador_if bus();

    rtc_secuenciador #(.REFRESH_CYCLES(REFRESH), .TIMEOUT(TOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp_val;
    } rd_vec_t;

    txn_t    exp_q[$];
    rd_vec_t vec[9];
    logic [7:0] sweep_tab[9];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         lat = 5;
    logic       noack_en = 1'b0;
    logic [7:0] noack_addr = 8'h00;
    logic [7:0] rd_off = 8'h00;
    int         done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] cached(input int i);
        case (i)
            0: cached = bus.seg;
            1: cached = bus.min;
            2: cached = bus.hora;
            3: cached = bus.dia;
            4: cached = bus.mes;
            5: cached = bus.anio;
            6: cached = bus.seg_t;
            7: cached = bus.min_t;
            default: cached = bus.hora_t;
        endcase
    endfunction

    // Engine model and transaction scoreboard: compares each launched transaction to the queue head
    initial begin : engine
        logic       pend;
        int         cnt;
        logic [7:0] cur_addr;
        logic       prev_start;
        txn_t       e;
        pend = 1'b0;
        cnt = 0;
        cur_addr = 8'h00;
        prev_start = 1'b0;
        bus.txn_done  = 1'b0;
        bus.txn_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.txn_done = 1'b0;
            if (reset) begin
                pend = 1'b0;
                prev_start = 1'b0;
                continue;
            end
            if (pend) begin
                if (cnt == 0) begin
                    bus.txn_done  = 1'b1;
                    bus.txn_rdata = cur_addr + 8'd1 + rd_off;
                    pend = 1'b0;
                    done_cyc = cyc;
                end else begin
                    cnt--;
                end
            end
            if (bus.txn_start) begin
                check("start_one_cycle", {31'd0, prev_start}, 32'd0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("txn_rw", {31'd0, bus.txn_rw}, {31'd0, e.rw});
                    check("txn_addr", {24'd0, bus.txn_addr}, {24'd0, e.addr});
                    if (!e.rw) check("txn_wdata", {24'd0, bus.txn_wdata}, {24'd0, e.wdata});
                end
                cur_addr = bus.txn_addr;
                if (!(noack_en && bus.txn_addr == noack_addr)) begin
                    pend = 1'b1;
                    cnt = lat - 1;
                end
            end
            prev_start = bus.txn_start;
        end
    end

    task automatic wait_sig(input int which, input int limit, output logic ok);
        logic s;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            case (which)
                0: s = bus.init_done;
                1: s = bus.sweep_done;
                2: s = bus.wr_ack;
                default: s = bus.bus_error;
            endcase
            if (s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input logic [7:0] a, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (bus.txn_start && bus.txn_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_init();
        exp_q.push_back('{1'b0, 8'h02, 8'h10});
        exp_q.push_back('{1'b0, 8'h02, 8'h00});
        exp_q.push_back('{1'b0, 8'h10, 8'hD2});
    endtask

    task automatic push_reads(input int from);
        for (int i = from; i < 9; i++) exp_q.push_back('{1'b1, sweep_tab[i], 8'h00});
    endtask

    task automatic check_vec(input string name);
        for (int i = 0; i < 9; i++) check(name, {24'd0, cached(i)}, {24'd0, vec[i].exp_val});
    endtask

    task automatic check_cleared(input string name);
        for (int i = 0; i < 9; i++) check(name, {24'd0, cached(i)}, 32'd0);
        check({name, "_init_done"}, {31'd0, bus.init_done}, 32'd0);
        check({name, "_bus_error"}, {31'd0, bus.bus_error}, 32'd0);
        check({name, "_txn_start"}, {31'd0, bus.txn_start}, 32'd0);
        check({name, "_wr_ack"}, {31'd0, bus.wr_ack}, 32'd0);
        check({name, "_sweep_done"}, {31'd0, bus.sweep_done}, 32'd0);
        check({name, "_txn_addr"}, {24'd0, bus.txn_addr}, 32'd0);
    endtask

    initial begin : main
        logic ok;
        int   t0;
        sweep_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        bus.wr_req  = 1'b0;
        bus.wr_addr = 8'h00;
        bus.wr_data = 8'h00;

        // Reset state and init sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        push_init();
        reset = 1'b0;
        wait_sig(0, 500, ok);
        check("init_done_seen", {31'd0, ok}, 32'd1);
        check("init_all_issued", exp_q.size(), 32'd0);
        for (int i = 0; i < 9; i++) vec[i] = '{sweep_tab[i], 8'h00};
        check_vec("init_cached");
        check("init_no_error", {31'd0, bus.bus_error}, 32'd0);

        // First sweep: data = addr + 1
        for (int i = 0; i < 9; i++) vec[i] = '{sweep_tab[i], sweep_tab[i] + 8'd1};
        push_reads(0);
        wait_sig(1, 1000, ok);
        check("sweep1_done_seen", {31'd0, ok}, 32'd1);
        check_vec("sweep1_cached");
        check("sweep1_all_issued", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
        check("sweep_done_pulse", {31'd0, bus.sweep_done}, 32'd0);

        // User write raised during the 0x22 read
        push_reads(8);
        exp_q.delete();
        exp_q.push_back('{1'b1, 8'h21, 8'h00});
        exp_q.push_back('{1'b1, 8'h22, 8'h00});
        exp_q.push_back('{1'b0, 8'h23, 8'h15});
        push_reads(2);
        wait_start(8'h22, 300, ok);
        check("wr_saw_read22", {31'd0, ok}, 32'd1);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 8'h23;
        bus.wr_data = 8'h15;
        wait_sig(2, 200, ok);
        check("wr_ack_seen", {31'd0, ok}, 32'd1);
        check("wr_ack_latency", cyc - done_cyc, 32'd1);
        bus.wr_req = 1'b0;
        @(posedge clk);
        #1;
        check("wr_ack_pulse", {31'd0, bus.wr_ack}, 32'd0);
        wait_sig(1, 1000, ok);
        check("wr_sweep_done", {31'd0, ok}, 32'd1);
        check("wr_all_issued", exp_q.size(), 32'd0);
        check_vec("wr_cached");

        // Read of 0x24 never acknowledged
        rd_off     = 8'h10;
        noack_addr = 8'h24;
        noack_en   = 1'b1;
        push_reads(0);
        wait_start(8'h24, 300, ok);
        check("to_saw_read24", {31'd0, ok}, 32'd1);
        check("to_err_before", {31'd0, bus.bus_error}, 32'd0);
        t0 = cyc;
        wait_sig(3, 100, ok);
        check("to_err_seen", {31'd0, ok}, 32'd1);
        check("to_err_cycles", cyc - t0, TOUT);
        noack_en = 1'b0;
        wait_sig(1, 1000, ok);
        check("to_sweep_done", {31'd0, ok}, 32'd1);
        check("to_all_issued", exp_q.size(), 32'd0);
        for (int i = 0; i < 9; i++) vec[i] = '{sweep_tab[i], sweep_tab[i] + 8'h11};
        vec[3].exp_val = 8'h25;
        check_vec("to_cached");
        check("to_err_sticky", {31'd0, bus.bus_error}, 32'd1);

        // Reset in the middle of a sweep
        rd_off = 8'h00;
        exp_q.delete();
        wait_start(8'h23, 300, ok);
        check("rst_saw_read23", {31'd0, ok}, 32'd1);
        reset = 1'b1;
        #1;
        check_cleared("midrst");
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        push_init();
        reset = 1'b0;
        wait_sig(0, 500, ok);
        check("rerun_init_done", {31'd0, ok}, 32'd1);
        check("rerun_all_issued", exp_q.size(), 32'd0);
        check("rerun_seg", {24'd0, bus.seg}, 32'd0);
        check("rerun_no_error", {31'd0, bus.bus_error}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rtc_secuenciador.md
# rtc_secuenciador

Transaction scheduler for the parallel RTC bus engine. It runs a fixed initialization write sequence after reset. It then periodically sweeps the nine time, date and timer registers, one read transaction each, and caches the results for the VGA path. It also arbitrates user edit writes (hour/date/timer change mode) into the sweep at transaction boundaries. It sits between the general control FSM/edit logic and the bus-protocol engine that drives ChipSelect/Read/Write/AoD.

## Interface
Parameters:
- REFRESH_CYCLES, 2_000_000 — period of sweep ticks in clk cycles (20 ms at 100 MHz).
- TIMEOUT, 1023 — max cycles to wait for txn_done before aborting a transaction.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  1  user write request; level, held until wr_ack.
- wr_addr  in  8  RTC register address for user write.
- wr_data  in  8  data for user write (BCD, already incremented/decremented).
- wr_ack  out  1  one-cycle pulse when the user write transaction completes or times out.
- txn_start  out  1  one-cycle pulse launching a bus transaction.
- txn_rw  out  1  1 = read, 0 = write (drives engine's IndicadorMaquina).
- txn_addr  out  8  transaction address.
- txn_wdata  out  8  write data.
- txn_done  in  1  one-cycle pulse from engine; txn_rdata valid in that cycle.
- txn_rdata  in  8  read data from engine.
- seg, min, hora, dia, mes, anio, seg_t, min_t, hora_t  out  8 each  cached register values.
- sweep_done  out  1  one-cycle pulse after the last read of a sweep is stored.
- init_done  out  1  high once the init sequence has finished.
- bus_error  out  1  sticky; set on any timeout.

## Operation
- Reset values: every output 0; state INIT; init index 0; refresh counter 0; tick_pending 0.
- Init sequence, writes in order:
  - addr 0x02 data 0x10
  - addr 0x02 data 0x00
  - addr 0x10 data 0xD2
  - After the third completes, init_done=1 and stays 1 until reset.
  - wr_req is not serviced during INIT.
- Refresh counter:
  - Counts 0..REFRESH_CYCLES-1 and wraps; runs from reset, including during INIT.
  - At wrap, tick_pending=1. The flag is single-deep: extra ticks while pending are dropped.
- Sweep read order and target registers:
  - 0x21→seg, 0x22→min, 0x23→hora
  - 0x24→dia, 0x25→mes, 0x26→anio
  - 0x41→seg_t, 0x42→min_t, 0x43→hora_t
- States:
  - INIT_ISSUE → INIT_WAIT → (next init write | IDLE).
  - IDLE: if wr_req, go to WR_ISSUE (priority). Else if tick_pending, clear it, set index 0, go to RD_ISSUE.
  - RD_ISSUE → RD_WAIT. On done: store txn_rdata into the indexed register and increment index.
    - If wr_req: go to WR_ISSUE with sweep_active kept.
    - Else if index<9: go to RD_ISSUE.
    - Else: pulse sweep_done, go to IDLE.
  - WR_ISSUE → WR_WAIT. On done: pulse wr_ack.
    - If sweep_active: resume RD_ISSUE at the saved index.
    - Else: go to IDLE.
- Arbitration:
  - An in-flight transaction is never preempted.
  - A user write is inserted only between reads.
  - Only one user write is inserted per read boundary; a still-held wr_req after wr_ack is treated as a new request.
- Timeout:
  - A WAIT-state counter reaching TIMEOUT sets bus_error and abandons the transaction.
  - Read: the register keeps its old value; the index still advances.
  - Write: wr_ack is still pulsed.
  - Init write: the sequence proceeds.
- txn_done arriving outside a WAIT state is ignored.

## Timing
- txn_start is high exactly one cycle, in the cycle after entering an ISSUE state.
- txn_rw, txn_addr and txn_wdata become valid in the start cycle and are held stable until the cycle after done or timeout.
- At least one idle cycle separates a done pulse from the next txn_start.
- Cached read register and sweep_done update on the clk edge following the txn_done cycle.
- wr_ack is asserted in the cycle after txn_done.
- If done and the timeout limit coincide in the same cycle, done wins: data is stored and no error is flagged.
- Asynchronous reset mid-transaction: everything returns to reset values immediately, and the init sequence restarts after reset deasserts.

## Test plan
- Reset release with the engine model acking after 5 cycles → three writes 0x02/0x10, 0x02/0x00, 0x10/0xD2 in order; init_done=1 after the third; all cached outputs 0.
- REFRESH_CYCLES=100, engine returning data = addr+1 → nine reads in order 0x21..0x43; seg=0x22 … hora_t=0x44; a single sweep_done pulse.
- wr_req (0x23, 0x15) raised during the read of 0x22 → the 0x22 read completes, then a write 0x23/0x15 with txn_rw=0, then wr_ack, then the sweep resumes at 0x23.
- Engine never acks read 0x24 (TIMEOUT=20) → after 20 cycles bus_error=1, dia unchanged, the sweep continues with 0x25.
- Reset asserted mid-sweep for 3 cycles → outputs cleared immediately; after release the init sequence reruns from the first write.
